dds_multi: RTL and testbench

- Multi-channel DDS phase-accumulator bank; successor to the single-channel binary DDS.
- Each channel has a frequency code, a phase offset, a waveform mode and an enable.
- Per-channel settings are written through a small register port into shadow registers. One global update strobe copies all shadows into the active set on the same cycle, so channels stay phase-coherent.
- Sits between the device-handler register decoder and the FPGA output pins or the DAC path.

---
 rtl/dds_multi_if.sv | 26 ++
 rtl/dds_multi.sv | 155 +++++++++++++++
 tb/tb_dds_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_multi_if.sv
// rtl/dds_multi_if.sv - register/update bus and sample outputs of the dds_multi bank
interface dds_multi_if #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter int NCH       = 4
);
  localparam int AW = ($clog2(NCH) + 2 < 2) ? 2 : $clog2(NCH) + 2;

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     update;
  logic                     phase_reset;
  logic [NCH*OUT_WIDTH-1:0] out;
  logic [NCH-1:0]           wrap;

  modport master (
    output wr_en, wr_addr, wr_data, update, phase_reset,
    input  out, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, update, phase_reset,
    output out, wrap
  );
endinterface

// File: rtl/dds_multi.sv
// rtl/dds_multi.sv - multi-channel DDS accumulator bank with shadowed, coherently updated settings
// Optional sine mode 3 and extra output stage enabled by macro DDS_MULTI_SINE_LUT_EN.
module dds_multi #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter int NCH       = 4
) (
  input  logic        clk,
  input  logic        nreset,
  dds_multi_if.slave  bus
);
  localparam int AW = ($clog2(NCH) + 2 < 2) ? 2 : $clog2(NCH) + 2;
  localparam logic [1:0] REG_FREQ = 2'd0;
  localparam logic [1:0] REG_OFFS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  logic [AW-1:0] wr_ch;
  logic [1:0]    wr_reg;
  assign wr_ch  = bus.wr_addr >> 2;
  assign wr_reg = bus.wr_addr[1:0];

  logic [NCH*OUT_WIDTH-1:0] out_all;
  logic [NCH-1:0]           wrap_all;

`ifdef DDS_MULTI_SINE_LUT_EN
  localparam int QN    = 2 ** (OUT_WIDTH - 2);
  localparam int AMP_I = 2 ** (OUT_WIDTH - 1) - 1;
  localparam logic [OUT_WIDTH-2:0] AMP = '1;
  localparam logic [OUT_WIDTH-1:0] MID = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-2:0] sine_entry(input int i);
    real v;
    v = real'(AMP_I) * $sin(2.0 * 3.14159265358979 * real'(i) / real'(4 * QN));
    return (OUT_WIDTH-1)'($rtoi(v + 0.5));
  endfunction

  // Quarter-wave table shared by all channels; only positive half magnitudes are stored.
  logic [OUT_WIDTH-2:0] sine_rom [QN];
  for (genvar i = 0; i < QN; i++) begin : g_rom
    assign sine_rom[i] = sine_entry(i);
  end
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [WIDTH-1:0]     sh_code, sh_off, act_code, act_off, acc, ph;
    logic [2:0]           sh_ctl, act_ctl;
    logic [WIDTH:0]       sum;
    logic [OUT_WIDTH-1:0] sample, out_q;
    logic                 wrap_q, sel;

    assign sel = bus.wr_en && (wr_ch == AW'(n));

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        sh_code <= '0;
        sh_off  <= '0;
        sh_ctl  <= '0;
      end else if (sel) begin
        case (wr_reg)
          REG_FREQ: sh_code <= bus.wr_data;
          REG_OFFS: sh_off  <= bus.wr_data;
          REG_CTRL: sh_ctl  <= bus.wr_data[2:0];
          default:  ;
        endcase
      end
    end

    // Active set samples the shadows before this cycle's write lands.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        act_code <= '0;
        act_off  <= '0;
        act_ctl  <= '0;
      end else if (bus.update) begin
        act_code <= sh_code;
        act_off  <= sh_off;
        act_ctl  <= sh_ctl;
      end
    end

    assign sum = {1'b0, acc} + {1'b0, act_code};

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        acc    <= '0;
        wrap_q <= 1'b0;
      end else if (bus.phase_reset) begin
        acc    <= '0;
        wrap_q <= 1'b0;
      end else if (act_ctl[2]) begin
        acc    <= sum[WIDTH-1:0];
        wrap_q <= sum[WIDTH];
      end else begin
        wrap_q <= 1'b0;
      end
    end

    assign ph = acc + act_off;

`ifdef DDS_MULTI_SINE_LUT_EN
    logic [1:0]           quad;
    logic [OUT_WIDTH-3:0] qaddr, ridx;
    logic [OUT_WIDTH-2:0] mag;
    logic [OUT_WIDTH-1:0] sine;

    assign quad  = ph[WIDTH-1:WIDTH-2];
    assign qaddr = ph[WIDTH-3 -: OUT_WIDTH-2];
    assign ridx  = quad[0] ? (~qaddr + 1'b1) : qaddr;
    // Mirrored address 0 in odd quadrants lands on the peak, which the table does not hold.
    assign mag   = (quad[0] && qaddr == '0) ? AMP : sine_rom[ridx];
    assign sine  = quad[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
`endif

    always_comb begin
      sample = ph[WIDTH-1 -: OUT_WIDTH];
      case (act_ctl[1:0])
        2'd0:    sample = {OUT_WIDTH{ph[WIDTH-1]}};
        2'd2:    sample = ph[WIDTH-2 -: OUT_WIDTH] ^ {OUT_WIDTH{ph[WIDTH-1]}};
`ifdef DDS_MULTI_SINE_LUT_EN
        2'd3:    sample = sine;
`endif
        default: sample = ph[WIDTH-1 -: OUT_WIDTH];
      endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) out_q <= '0;
      else         out_q <= sample;
    end

`ifdef DDS_MULTI_SINE_LUT_EN
    logic [OUT_WIDTH-1:0] out_d;
    logic                 wrap_d;

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        out_d  <= '0;
        wrap_d <= 1'b0;
      end else begin
        out_d  <= out_q;
        wrap_d <= wrap_q;
      end
    end

    assign out_all[n*OUT_WIDTH +: OUT_WIDTH] = out_d;
    assign wrap_all[n]                      = wrap_d;
`else
    assign out_all[n*OUT_WIDTH +: OUT_WIDTH] = out_q;
    assign wrap_all[n]                      = wrap_q;
`endif
  end

  assign bus.out  = out_all;
  assign bus.wrap = wrap_all;
endmodule

// File: tb/tb_dds_multi.sv
// tb/tb_dds_multi.sv - directed and random checks of dds_multi against a phase-arithmetic model
module tb_dds_multi;
  localparam int W   = 16;
  localparam int OW  = 4;
  localparam int NCH = 2;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  dds_multi_if #(.WIDTH(W), .OUT_WIDTH(OW), .NCH(NCH)) bus ();
  dds_multi #(.WIDTH(W), .OUT_WIDTH(OW), .NCH(NCH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned s_code [NCH], s_off [NCH], s_ctl [NCH];
  int unsigned a_code [NCH], a_off [NCH], a_ctl [NCH];
  int unsigned m_acc [NCH], m_out [NCH], m_wrap [NCH];

  function automatic int unsigned ref_sample(int unsigned ph, int unsigned mode);
    int unsigned half     = 1 << (W - 1);
    int unsigned step_saw = 1 << (W - OW);
    int unsigned step_tri = 1 << (W - OW - 1);
    int unsigned top      = (1 << OW) - 1;
    case (mode)
      0:       return (ph >= half) ? top : 0;
      2:       return (ph < half) ? ph / step_tri : top - (ph - half) / step_tri;
      default: return ph / step_saw;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      s_code[n] = 0; s_off[n] = 0; s_ctl[n] = 0;
      a_code[n] = 0; a_off[n] = 0; a_ctl[n] = 0;
      m_acc[n] = 0; m_out[n] = 0; m_wrap[n] = 0;
    end
  endtask

  task automatic model_edge();
    int unsigned ch, rg, sum;
    ch = int'(bus.wr_addr) >> 2;
    rg = int'(bus.wr_addr) & 3;
    for (int n = 0; n < NCH; n++) begin
      m_out[n] = ref_sample((m_acc[n] + a_off[n]) % 65536, a_ctl[n] & 3);
      if (bus.phase_reset) begin
        m_acc[n] = 0; m_wrap[n] = 0;
      end else if ((a_ctl[n] >> 2) & 1) begin
        sum = m_acc[n] + a_code[n];
        m_wrap[n] = (sum >= 65536) ? 1 : 0;
        m_acc[n] = sum % 65536;
      end else begin
        m_wrap[n] = 0;
      end
      if (bus.update) begin
        a_code[n] = s_code[n]; a_off[n] = s_off[n]; a_ctl[n] = s_ctl[n];
      end
    end
    if (bus.wr_en && ch < NCH) begin
      case (rg)
        0: s_code[ch] = int'(bus.wr_data);
        1: s_off[ch]  = int'(bus.wr_data);
        2: s_ctl[ch]  = int'(bus.wr_data) & 7;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < NCH; n++) begin
      chk($sformatf("%s out%0d", tag, n), 32'(bus.out[n*OW +: OW]), m_out[n]);
      chk($sformatf("%s wrap%0d", tag, n), 32'(bus.wrap[n]), m_wrap[n]);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit we, input int ch, input int rg, input int unsigned d,
                       input bit upd, input bit pr, input string tag);
    bus.wr_en       = we;
    bus.wr_addr     = 3'((ch << 2) | rg);
    bus.wr_data     = 16'(d);
    bus.update      = upd;
    bus.phase_reset = pr;
    cyc(tag);
    bus.wr_en       = 1'b0;
    bus.update      = 1'b0;
    bus.phase_reset = 1'b0;
  endtask

  task automatic wr(input int ch, input int rg, input int unsigned d);
    drive(1'b1, ch, rg, d, 1'b0, 1'b0, "wr");
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  int exp_saw  [8] = '{0, 2, 4, 7, 9, 12, 14, 1};
  int exp_wrp  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int exp_tri  [8] = '{0, 4, 8, 12, 15, 11, 7, 3};

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.update = 1'b0; bus.phase_reset = 1'b0;
    model_reset();

    // reset state, checked while reset is held across clock edges
    #23;
    check_all("reset");
    @(negedge clk);
    nreset = 1'b1;
    idle(2, "post_reset");

    // sawtooth ch0, code 10000, explicit sample and wrap sequence
    wr(0, 0, 10000);
    wr(0, 2, 5);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1, "upd_pr");
    for (int k = 0; k < 8; k++) begin
      cyc("saw");
      chk($sformatf("saw_seq[%0d]", k), 32'(bus.out[0 +: OW]), exp_saw[k]);
      chk($sformatf("saw_wrap[%0d]", k), 32'(bus.wrap[0]), exp_wrp[k]);
    end

    // square ch1, then inverted by offset
    wr(1, 0, 10000);
    wr(1, 1, 0);
    wr(1, 2, 4);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1, "sq_start");
    for (int k = 0; k < 8; k++) begin
      cyc("square");
      chk($sformatf("sq_seq[%0d]", k), 32'(bus.out[OW +: OW]), (k >= 4 && k <= 6) ? 15 : 0);
    end
    wr(1, 1, 32768);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, "sq_inv_upd");
    idle(8, "square_inv");

    // triangle ch0, code 8192
    wr(0, 0, 8192);
    wr(0, 2, 6);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1, "tri_start");
    for (int k = 0; k < 16; k++) begin
      cyc("triangle");
      chk($sformatf("tri_seq[%0d]", k), 32'(bus.out[0 +: OW]), exp_tri[k % 8]);
    end

    // shadow-only write, then update colliding with a write, then plain update
    wr(0, 2, 5);
    wr(0, 0, 20000);
    idle(4, "shadow_only");
    drive(1'b1, 0, 0, 30000, 1'b1, 1'b0, "upd_wr");
    idle(4, "active_20000");
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, "upd2");
    idle(4, "active_30000");

    // asynchronous reset mid-run, outputs clear without a clock edge
    #2;
    nreset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    nreset = 1'b1;
    idle(5, "after_rst");

    // disabled channel holds, then code 0 with offset gives a constant output
    wr(0, 0, 5000);
    wr(0, 2, 1);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, "dis_upd");
    idle(5, "disabled");
    wr(0, 0, 0);
    wr(0, 1, 45000);
    wr(0, 2, 5);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, "frozen_upd");
    idle(5, "frozen");

    // random register traffic, updates and phase resets
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 1) == 1), $urandom_range(0, NCH - 1), $urandom_range(0, 3),
            $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
